// File: rtl/ks_adder_pipe_if.sv
// Valid/ready operand and result bus for ks_adder_pipe.
// The SAT lane exists only when KS_ADDER_SAT_EN is defined.
interface ks_adder_pipe_if #(
   parameter int WIDTH = 28
);
   logic             IN_VALID;
   logic             IN_READY;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             CIN;
   logic             SUB;
`ifdef KS_ADDER_SAT_EN
   logic             SAT;
`endif
   logic             OUT_VALID;
   logic             OUT_READY;
   logic [WIDTH-1:0] SUM;
   logic             COUT;
   logic             OVF;

   modport master (
`ifdef KS_ADDER_SAT_EN
      output SAT,
`endif
      output IN_VALID, A, B, CIN, SUB, OUT_READY,
      input  IN_READY, OUT_VALID, SUM, COUT, OVF
   );

   modport slave (
`ifdef KS_ADDER_SAT_EN
      input  SAT,
`endif
      input  IN_VALID, A, B, CIN, SUB, OUT_READY,
      output IN_READY, OUT_VALID, SUM, COUT, OVF
   );
endinterface

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with a global-stall valid/ready pipeline.
// Define KS_ADDER_SAT_EN to add the SAT lane and signed saturation of SUM.
module ks_adder_pipe #(
   parameter int WIDTH = 28
) (
   input logic            CLK,
   input logic            RST,
   ks_adder_pipe_if.slave bus
);
   localparam int LVLS = $clog2(WIDTH);

   logic             stall_s;
   logic [WIDTH-1:0] be_s;
   logic             ce_s;
   logic [WIDTH-1:0] ext_g_s;
   logic [WIDTH-1:0] ext_p_s;
   logic [WIDTH-1:0] lvl_g_s [1:LVLS];
   logic [WIDTH-1:0] lvl_p_s [1:LVLS];

   // Stage 0 is the input register, stage k holds the result of prefix level k.
   logic             stg_valid_r [0:LVLS];
   logic [WIDTH-1:0] stg_g_r     [0:LVLS];
   logic [WIDTH-1:0] stg_p_r     [0:LVLS];
   logic [WIDTH-1:0] stg_x_r     [0:LVLS];
   logic             stg_gm_r    [0:LVLS];
   logic             stg_am_r    [0:LVLS];
`ifdef KS_ADDER_SAT_EN
   logic             stg_sat_r   [0:LVLS];
   localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

   logic [WIDTH-1:0] sum_s;
   logic [WIDTH-1:0] res_s;
   logic             cout_s;
   logic             ovf_s;
   logic             out_valid_r;
   logic [WIDTH-1:0] sum_r;
   logic             cout_r;
   logic             ovf_r;

   assign stall_s       = out_valid_r && !bus.OUT_READY;
   assign bus.IN_READY  = !stall_s;
   assign bus.OUT_VALID = out_valid_r;
   assign bus.SUM       = sum_r;
   assign bus.COUT      = cout_r;
   assign bus.OVF       = ovf_r;

   // Effective operand and carry-in for add or subtract.
   always_comb begin
      be_s = bus.B;
      ce_s = bus.CIN;
      if (bus.SUB) begin
         be_s = ~bus.B;
         ce_s = 1'b1;
      end else begin
         be_s = bus.B;
         ce_s = bus.CIN;
      end
   end

   // Node 0 is the carry-in as a pure generate; node j is operand bit j-1.
   // The MSB's own g/p never feed the prefix tree, so they ride along separately.
   assign ext_g_s = {bus.A[WIDTH-2:0] & be_s[WIDTH-2:0], ce_s};
   assign ext_p_s = {bus.A[WIDTH-2:0] ^ be_s[WIDTH-2:0], 1'b0};

   // Bits shifted in as zero leave nodes below SPAN untouched; their P is already 0.
   for (genvar k = 1; k <= LVLS; k++) begin : g_lvl
      localparam int SPAN = 1 << (k - 1);
      assign lvl_g_s[k] = stg_g_r[k-1] | (stg_p_r[k-1] & (stg_g_r[k-1] << SPAN));
      assign lvl_p_s[k] = stg_p_r[k-1] & (stg_p_r[k-1] << SPAN);
   end

   // Input register and prefix-level registers; every stage freezes on stall.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int k = 0; k <= LVLS; k++) begin
            stg_valid_r[k] <= 1'b0;
            stg_g_r[k]     <= {WIDTH{1'b0}};
            stg_p_r[k]     <= {WIDTH{1'b0}};
            stg_x_r[k]     <= {WIDTH{1'b0}};
            stg_gm_r[k]    <= 1'b0;
            stg_am_r[k]    <= 1'b0;
`ifdef KS_ADDER_SAT_EN
            stg_sat_r[k]   <= 1'b0;
`endif
         end
      end else if (!stall_s) begin
         stg_valid_r[0] <= bus.IN_VALID;
         stg_g_r[0]     <= ext_g_s;
         stg_p_r[0]     <= ext_p_s;
         stg_x_r[0]     <= bus.A ^ be_s;
         stg_gm_r[0]    <= bus.A[WIDTH-1] & be_s[WIDTH-1];
         stg_am_r[0]    <= bus.A[WIDTH-1];
`ifdef KS_ADDER_SAT_EN
         stg_sat_r[0]   <= bus.SAT;
`endif
         for (int k = 1; k <= LVLS; k++) begin
            stg_valid_r[k] <= stg_valid_r[k-1];
            stg_g_r[k]     <= lvl_g_s[k];
            stg_p_r[k]     <= lvl_p_s[k];
            stg_x_r[k]     <= stg_x_r[k-1];
            stg_gm_r[k]    <= stg_gm_r[k-1];
            stg_am_r[k]    <= stg_am_r[k-1];
`ifdef KS_ADDER_SAT_EN
            stg_sat_r[k]   <= stg_sat_r[k-1];
`endif
         end
      end
   end

   // Sum stage: final group generates are the carries into each bit.
   always_comb begin
      sum_s  = stg_x_r[LVLS] ^ stg_g_r[LVLS];
      cout_s = stg_gm_r[LVLS] | (stg_x_r[LVLS][WIDTH-1] & stg_g_r[LVLS][WIDTH-1]);
      ovf_s  = !stg_x_r[LVLS][WIDTH-1] && (sum_s[WIDTH-1] != stg_am_r[LVLS]);
      res_s  = sum_s;
`ifdef KS_ADDER_SAT_EN
      if (stg_sat_r[LVLS] && ovf_s) begin
         if (stg_am_r[LVLS]) begin
            res_s = SAT_MIN;
         end else begin
            res_s = SAT_MAX;
         end
      end else begin
         res_s = sum_s;
      end
`endif
   end

   // Output register; holds its beat while downstream is not ready.
   always_ff @(posedge CLK) begin
      if (RST) begin
         out_valid_r <= 1'b0;
         sum_r       <= {WIDTH{1'b0}};
         cout_r      <= 1'b0;
         ovf_r       <= 1'b0;
      end else if (!stall_s) begin
         out_valid_r <= stg_valid_r[LVLS];
         sum_r       <= res_s;
         cout_r      <= cout_s;
         ovf_r       <= ovf_s;
      end
   end
endmodule

// File: tb/tb_ks_adder_pipe.sv
// Randomized self-checking bench for ks_adder_pipe against an arithmetic reference model.
module tb_ks_adder_pipe;
   parameter int WIDTH = 28;
   localparam int LVLS = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] ONES = '1;
   localparam logic [WIDTH-1:0] SMAX = ONES >> 1;
   localparam logic [WIDTH-1:0] SMIN = ~SMAX;
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
      int               acc_cyc;
      int               acc_stall;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_deliv = 0;
   int   stall_cnt = 0;
   int   stall_lo = -10;
   int   stall_hi = -20;
   bit   rand_rdy = 1'b0;
   bit   front_seen = 1'b0;
   exp_t exp_q[$];
   logic [WIDTH-1:0] last_sum;
   logic             last_cout;
   logic             last_ovf;
   int               last_lat;

   ks_adder_pipe_if #(.WIDTH(WIDTH)) bus ();
   ks_adder_pipe #(.WIDTH(WIDTH)) dut (.CLK(clk), .RST(rst), .bus(bus));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: unsigned W+1-bit sum for SUM/COUT, true signed range test for OVF.
   function automatic exp_t ref_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                      input logic cin, input logic sub, input logic sat);
      exp_t r;
      logic [WIDTH-1:0] be;
      logic             ce;
      logic [WIDTH:0]   uns;
      logic signed [WIDTH+1:0] sgn;
      be  = sub ? ~b : b;
      ce  = sub ? 1'b1 : cin;
      uns = {1'b0, a} + {1'b0, be} + {{WIDTH{1'b0}}, ce};
      sgn = $signed({{2{a[WIDTH-1]}}, a}) + $signed({{2{be[WIDTH-1]}}, be})
            + $signed({{(WIDTH+1){1'b0}}, ce});
      r.sum  = uns[WIDTH-1:0];
      r.cout = uns[WIDTH];
      r.ovf  = (sgn > $signed({2'b00, SMAX})) || (sgn < $signed({2'b11, SMIN}));
      if (sat && r.ovf) r.sum = a[WIDTH-1] ? SMIN : SMAX;
      r.acc_cyc   = 0;
      r.acc_stall = 0;
      return r;
   endfunction

   function automatic logic [WIDTH-1:0] rnd_op();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      case ($urandom_range(0, 7))
         0: return ONES;
         1: return '0;
         2: return SMAX;
         3: return SMIN;
         default: return r[WIDTH-1:0];
      endcase
   endfunction

   // Downstream ready: random mode, or low inside the scheduled stall window.
   initial begin
      bus.OUT_READY = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rand_rdy) bus.OUT_READY = ($urandom_range(0, 1) == 1);
         else          bus.OUT_READY = !(cyc >= stall_lo && cyc <= stall_hi);
      end
   end

   // Monitor/scoreboard, sampled mid-cycle where inputs and outputs are settled.
   initial begin
      exp_t e;
      int   lat_exp;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
            front_seen = 1'b0;
         end else begin
            if (bus.OUT_VALID && !bus.OUT_READY) check_eq("in_ready_stall", bus.IN_READY, 0);
            else                                 check_eq("in_ready_free", bus.IN_READY, 1);
            if (bus.OUT_VALID) begin
               if (exp_q.size() == 0) begin
                  check_eq("unexpected_out", bus.OUT_VALID, 0);
               end else begin
                  e = exp_q[0];
                  if (!front_seen) begin
                     lat_exp  = LVLS + 2 + (stall_cnt - e.acc_stall);
                     last_lat = cyc - e.acc_cyc;
                     check_eq("latency", last_lat, lat_exp);
                     front_seen = 1'b1;
                  end
                  check_eq("sum", bus.SUM, e.sum);
                  check_eq("cout", bus.COUT, e.cout);
                  check_eq("ovf", bus.OVF, e.ovf);
                  if (bus.OUT_READY) begin
                     last_sum  = bus.SUM;
                     last_cout = bus.COUT;
                     last_ovf  = bus.OVF;
                     void'(exp_q.pop_front());
                     front_seen = 1'b0;
                     n_deliv++;
                  end
               end
               if (!bus.OUT_READY) stall_cnt++;
            end
            if (bus.IN_VALID && bus.IN_READY) begin
`ifdef KS_ADDER_SAT_EN
               e = ref_model(bus.A, bus.B, bus.CIN, bus.SUB, bus.SAT);
`else
               e = ref_model(bus.A, bus.B, bus.CIN, bus.SUB, 1'b0);
`endif
               e.acc_cyc   = cyc;
               e.acc_stall = stall_cnt;
               exp_q.push_back(e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic cin, input logic sub, input logic sat);
      int   waited = 0;
      logic acc;
      bus.A = a;
      bus.B = b;
      bus.CIN = cin;
      bus.SUB = sub;
`ifdef KS_ADDER_SAT_EN
      bus.SAT = sat;
`else
      if (sat) bus.CIN = cin;
`endif
      bus.IN_VALID = 1'b1;
      do begin
         @(negedge clk);
         acc = bus.IN_READY;
         tick();
         waited++;
      end while (!acc && waited < 100);
      if (!acc) check_eq("accept_timeout", acc, 1);
   endtask

   task automatic idle();
      bus.IN_VALID = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      idle();
      while (exp_q.size() != 0 && n < 400) begin
         tick();
         n++;
      end
      check_eq("drain", exp_q.size(), 0);
   endtask

   initial begin
      int   d0;
      int   s0;
      exp_t e;
      #200000;
      $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int   d0;
      int   s0;
      exp_t e;
      rst = 1'b1;
      bus.IN_VALID = 1'b0;
      bus.A = '0;
      bus.B = '0;
      bus.CIN = 1'b0;
      bus.SUB = 1'b0;
`ifdef KS_ADDER_SAT_EN
      bus.SAT = 1'b0;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_out_valid", bus.OUT_VALID, 0);
      check_eq("rst_sum", bus.SUM, 0);
      check_eq("rst_cout", bus.COUT, 0);
      check_eq("rst_ovf", bus.OVF, 0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check_eq("post_rst_in_ready", bus.IN_READY, 1);
      tick();

      // Carry ripples across the low bits only.
      send(ONES >> 4, ONE, 1'b0, 1'b0, 1'b0);
      drain();
      check_eq("d1_sum", last_sum, ONE << (WIDTH - 4));
      check_eq("d1_cout", last_cout, 0);
      check_eq("d1_ovf", last_ovf, 0);
      check_eq("d1_latency", last_lat, LVLS + 2);

      // Positive overflow, wrapping and (optionally) saturating.
      send(SMAX, ONE, 1'b0, 1'b0, 1'b0);
      drain();
      check_eq("d2_sum", last_sum, SMIN);
      check_eq("d2_ovf", last_ovf, 1);
`ifdef KS_ADDER_SAT_EN
      send(SMAX, ONE, 1'b0, 1'b0, 1'b1);
      drain();
      check_eq("d2_sat_sum", last_sum, SMAX);
      check_eq("d2_sat_ovf", last_ovf, 1);
`endif

      send(WIDTH'(5), WIDTH'(7), 1'b0, 1'b1, 1'b0);
      drain();
      check_eq("d3_sum", last_sum, ONES - ONE);
      check_eq("d3_cout", last_cout, 0);
      check_eq("d3_ovf", last_ovf, 0);

      send(ONES, ONES, 1'b1, 1'b0, 1'b0);
      drain();
      check_eq("d4_sum", last_sum, ONES);
      check_eq("d4_cout", last_cout, 1);

      // Back-to-back stream with downstream stalled for five cycles.
      d0 = n_deliv;
      s0 = stall_cnt;
      stall_lo = cyc + 10;
      stall_hi = cyc + 14;
      for (int i = 0; i < 20; i++) begin
         send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
      end
      drain();
      check_eq("stream_count", n_deliv - d0, 20);
      check_eq("stream_stalls", stall_cnt - s0, 5);

      // Bubbles and random backpressure.
      rand_rdy = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            idle();
            tick();
         end else begin
            send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
         end
      end
      rand_rdy = 1'b0;
      drain();

      // Reset with four beats in flight: none of them may emerge.
      d0 = n_deliv;
      for (int i = 0; i < 4; i++) send(rnd_op(), rnd_op(), 1'b0, 1'b0, 1'b0);
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check_eq("mid_rst_out_valid", bus.OUT_VALID, 0);
      check_eq("mid_rst_sum", bus.SUM, 0);
      check_eq("mid_rst_cout", bus.COUT, 0);
      check_eq("mid_rst_ovf", bus.OVF, 0);
      repeat (LVLS + 4) tick();
      check_eq("mid_rst_no_deliv", n_deliv - d0, 0);
      e = ref_model(WIDTH'(32'h0000_0123), WIDTH'(32'h0000_0456), 1'b0, 1'b0, 1'b0);
      send(WIDTH'(32'h0000_0123), WIDTH'(32'h0000_0456), 1'b0, 1'b0, 1'b0);
      drain();
      check_eq("post_rst_sum", last_sum, e.sum);
      check_eq("post_rst_latency", last_lat, LVLS + 2);
      check_eq("post_rst_deliv", n_deliv - d0, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
